alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Micro-sequencer for the shared 8-bit ALU (ops: 000 NOT A, 001 OR, 010 XOR, 011 AND, 100 MUL A[3:0]*B[3:0], 101 ADD, 110 SUB).
Holds a small program of (op, B-operand) slots and runs them back-to-back through the combinational ALU, with an 8-bit accumulator as operand A. Host loads the program, pulses start, then waits for done and reads result.
Sits between the host/test logic and the ALU; the ALU is instantiated outside this block and connected through the alu_* ports.

Parameters:
DEPTH, 8, number of program slots; fixed at 8 in this revision.
ADDR_W, 3, slot address width (log2 DEPTH).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
prog_we  in  1  write one program slot; honoured only in IDLE.
prog_addr  in  ADDR_W  slot index to write.
prog_op  in  3  ALU opcode for the slot.
prog_b  in  8  B operand for the slot.
init_a  in  8  accumulator seed; sampled on accepted start.
len  in  4  number of slots to execute (0..8; values >8 clamp to 8); sampled on accepted start.
start  in  1  begin execution; honoured only in IDLE.
alu_a  out  8  to ALU A; equals accumulator.
alu_b  out  8  to ALU B; equals prog_b of slot pc.
alu_op  out  3  to ALU op; equals prog_op of slot pc.
alu_out  in  8  ALU result, combinational from alu_a/alu_b/alu_op.
busy  out  1  high while in EXEC.
done  out  1  one-cycle pulse on completion.
err  out  1  illegal opcode (111) hit; sticky until next accepted start.
result  out  8  accumulator value; stable from done until next accepted start.
step_valid  out  1  high in each EXEC cycle (one op commits at the end of that cycle).
step_idx  out  ADDR_W  current pc, for tracing.

Behaviour:
- Reset: state IDLE; acc=0, pc=0, len_r=0, err=0, all 8 slots cleared to op 000, b 0x00. Outputs then: busy 0, done 0, result 0, err 0, alu_a 0, alu_b 0, alu_op 000, step_valid 0, step_idx 0. Reset has priority over start/prog_we and aborts any running program, with no done pulse.
- States: IDLE, EXEC, DONE.
- IDLE:
  - prog_we writes slot[prog_addr] at the clock edge.
  - start: acc<=init_a, pc<=0, err<=0, len_r<=min(len,8).
    - len_r>0: go to EXEC.
    - len=0: go directly to DONE; result=init_a.
  - prog_we and start in the same cycle: the write lands first; the program runs with the new slot content.
- EXEC, each cycle:
  - op = slot[pc].op.
  - op != 111: acc<=alu_out at the edge. If pc==len_r-1, go to DONE; else pc<=pc+1.
  - op == 111: acc unchanged, err<=1, go to DONE immediately; remaining slots are skipped.
  - One op per clock; the acc->ALU->acc path is a single-cycle combinational loop.
- DONE: done=1 for exactly one cycle, then IDLE. pc holds its last value.
- start, prog_we and len are ignored in EXEC and DONE; the program is frozen while running.
- Latency: start edge E0; ops commit at E1..En; done is high in the cycle after En. Total n+1 cycles from the start edge to the done cycle; busy is high for n cycles.
- Width rules: all arithmetic is mod 2^8 and is performed by the ALU; the sequencer never widens or saturates. SUB wrap (e.g. 0x08-0x0A=0xFE) passes through unchanged.
- result==acc at all times; hosts read it only after done.

Test Plan:
1. Program slots 0..5 = (001,0x0F),(010,0xAA),(011,0x0F),(101,0x03),(110,0x0A),(100,0x03); init_a=0xF0, len=6, start -> acc sequence FF,55,05,08,FE,2A; done in the 7th cycle after the start edge; result=0x2A; err=0; busy high for 6 cycles.
2. Slot0=(000,any), init_a=0xF0, len=1 -> result=0x0F; done 2 cycles after start.
3. len=0, init_a=0x5A -> done the cycle after start; result=0x5A; no step_valid pulses.
4. Slot1=(111,..), len=4, init_a=0x10, slot0=(101,0x01) -> result=0x11; err=1; done after 2 EXEC cycles; slots 2-3 not executed.
5. Assert rst during the 3rd EXEC cycle of scenario 1 -> next cycle IDLE, result=0, no done pulse. Rerun after reloading: slots read 000/0x00 until rewritten.
6. Pulse start and prog_we(slot0=(001,0xFF)) during EXEC -> both ignored, scenario-1 result unchanged. Then prog_we+start in the same IDLE cycle with len=1 -> new slot used; result = init_a|0xFF = 0xFF.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Runs a small (op, B) program back-to-back through an external
//            combinational ALU, using an 8-bit accumulator as operand A.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [2:0]        prog_op,
    input  logic [7:0]        prog_b,
    input  logic [7:0]        init_a,
    input  logic [3:0]        len,
    input  logic              start,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    input  logic [7:0]        alu_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        result,
    output logic              step_valid,
    output logic [ADDR_W-1:0] step_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_DEPTH   = 4'(DEPTH);
    localparam logic [2:0] C_OP_ILL  = 3'b111;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_slot_op [DEPTH];
    logic [7:0]        r_slot_b  [DEPTH];
    logic [7:0]        r_acc;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_len;
    logic              r_err;

    logic [2:0]        w_cur_op;
    logic              w_illegal;
    logic              w_last;
    logic [3:0]        w_len_clamp;

    assign w_cur_op    = r_slot_op[r_pc];
    assign w_illegal   = (w_cur_op == C_OP_ILL);
    assign w_last      = (4'(r_pc) == (r_len - 4'd1));
    assign w_len_clamp = (len > C_DEPTH) ? C_DEPTH : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_len_clamp == 4'd0) ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_illegal || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Program writes land before a same-cycle start, so the run sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'h00;
            r_pc  <= '0;
            r_len <= 4'd0;
            r_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_op[i] <= 3'b000;
                r_slot_b[i]  <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (prog_we) begin
                        r_slot_op[prog_addr] <= prog_op;
                        r_slot_b[prog_addr]  <= prog_b;
                    end
                    if (start) begin
                        r_acc <= init_a;
                        r_pc  <= '0;
                        r_err <= 1'b0;
                        r_len <= w_len_clamp;
                    end
                end
                S_EXEC: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else begin
                        r_acc <= alu_out;
                        if (!w_last) begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = r_acc;
    assign alu_b      = r_slot_b[r_pc];
    assign alu_op     = w_cur_op;
    assign busy       = (r_state == S_EXEC);
    assign step_valid = (r_state == S_EXEC);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign result     = r_acc;
    assign step_idx   = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed plus random program runs against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [2:0] prog_op;
    logic [7:0] prog_b;
    logic [7:0] init_a;
    logic [3:0] len;
    logic       start;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic       step_valid;
    logic [2:0] step_idx;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_op [8];
    logic [7:0] m_b  [8];
    logic [7:0] exp_res;
    logic       exp_err;
    int         exp_steps;
    logic [7:0] exp_trace [8];

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_op    (prog_op),
        .prog_b     (prog_b),
        .init_a     (init_a),
        .len        (len),
        .start      (start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .step_valid (step_valid),
        .step_idx   (step_idx)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a & b;
            3'd4:    return 8'(a[3:0] * b[3:0]);
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_run(input logic [7:0] a0, input logic [3:0] ln);
        int n;
        logic [7:0] acc;
        n         = (ln > 4'd8) ? 8 : int'(ln);
        acc       = a0;
        exp_err   = 1'b0;
        exp_steps = n;
        for (int i = 0; i < 8; i++) exp_trace[i] = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_trace[i] = acc;
            if (m_op[i] == 3'b111) begin
                exp_err   = 1'b1;
                exp_steps = i + 1;
                break;
            end
            acc = alu_f(acc, m_b[i], m_op[i]);
        end
        exp_res = acc;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_op[i] = 3'b000;
            m_b[i]  = 8'h00;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] op, input logic [7:0] b);
        prog_we = 1'b1; prog_addr = a; prog_op = op; prog_b = b;
        m_op[a] = op; m_b[a] = b;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic kick(input logic [7:0] a0, input logic [3:0] ln);
        init_a = a0; len = ln; start = 1'b1;
    endtask

    // Start must already be driven; inject=1 pokes start/prog_we mid-run.
    task automatic check_run(input string tag, input logic [7:0] a0, input logic [3:0] ln, input bit inject);
        int done_cyc = 0;
        int busy_cnt = 0;
        int idx      = 0;
        model_run(a0, ln);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cnt++;
            if (step_valid && idx < 8) begin
                chk({tag, "_idx"}, step_idx, idx);
                chk({tag, "_acc"}, alu_a, exp_trace[idx]);
                idx++;
            end
            if (inject && cyc == 2) begin
                start = 1'b1; init_a = 8'h77; len = 4'd1;
                prog_we = 1'b1; prog_addr = 3'd0; prog_op = 3'b001; prog_b = 8'hFF;
            end
        end
        chk({tag, "_done_cyc"}, done_cyc, exp_steps + 1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy"}, busy_cnt, exp_steps);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 1'b0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    task automatic load_s1();
        wr(3'd0, 3'b001, 8'h0F);
        wr(3'd1, 3'b010, 8'hAA);
        wr(3'd2, 3'b011, 8'h0F);
        wr(3'd3, 3'b101, 8'h03);
        wr(3'd4, 3'b110, 8'h0A);
        wr(3'd5, 3'b100, 8'h03);
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_b = '0;
        init_a = '0; len = '0; start = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_res", result, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 19'h0);
        chk("rst_step", {step_valid, step_idx}, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: full mixed-op program.
        load_s1();
        kick(8'hF0, 4'd6);
        check_run("s1", 8'hF0, 4'd6, 1'b0);
        chk("s1_const", result, 8'h2A);

        // Scenario 2: single NOT.
        wr(3'd0, 3'b000, 8'h33);
        kick(8'hF0, 4'd1);
        check_run("s2", 8'hF0, 4'd1, 1'b0);
        chk("s2_const", result, 8'h0F);

        // Scenario 3: empty program.
        kick(8'h5A, 4'd0);
        check_run("s3", 8'h5A, 4'd0, 1'b0);
        chk("s3_const", result, 8'h5A);

        // Scenario 4: illegal op aborts.
        wr(3'd0, 3'b101, 8'h01);
        wr(3'd1, 3'b111, 8'h00);
        kick(8'h10, 4'd4);
        check_run("s4", 8'h10, 4'd4, 1'b0);
        chk("s4_const", {err, result}, 9'h111);

        // Scenario 5: reset during 3rd EXEC cycle.
        load_s1();
        kick(8'hF0, 4'd6);
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("s5_mid", {busy, step_idx}, 4'b1010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        chk("s5_busy", busy, 1'b0);
        chk("s5_res", result, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("s5_nodone", done, 1'b0);
            @(negedge clk);
        end
        kick(8'h33, 4'd8);
        check_run("s5_clr", 8'h33, 4'd8, 1'b0);

        // Scenario 6: writes/start ignored while running; then combined write+start.
        load_s1();
        kick(8'hF0, 4'd6);
        check_run("s6", 8'hF0, 4'd6, 1'b1);
        chk("s6_const", result, 8'h2A);
        prog_we = 1'b1; prog_addr = 3'd0; prog_op = 3'b001; prog_b = 8'hFF;
        m_op[0] = 3'b001; m_b[0] = 8'hFF;
        kick(8'h12, 4'd1);
        check_run("s6b", 8'h12, 4'd1, 1'b0);
        chk("s6b_const", result, 8'hFF);

        // Random programs, including len clamping and illegal ops.
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 8);
            for (int k = 0; k < nw; k++) begin
                logic [2:0] op;
                op = ($urandom_range(0, 11) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
                wr(3'($urandom_range(0, 7)), op, 8'($urandom));
            end
            begin
                logic [7:0] a0;
                logic [3:0] ln;
                a0 = 8'($urandom);
                ln = 4'($urandom_range(0, 15));
                kick(a0, ln);
                check_run("rnd", a0, ln, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
